res_dispatch: RTL

RES_DISPATCH -- requirements
Module: res_dispatch

---
 rtl/res_dispatch_if.sv | 53 +++++
 rtl/res_dispatch.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/res_dispatch_if.sv
// Shared tomasula word/CDB types plus the dispatch bus between instruction queue,
// reservation stations and the dispatcher.
package tomasula_types;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 3;
    localparam logic [6:0]  OP_JALR = 7'b1100111;
    localparam logic [6:0]  OP_ADDI = 7'b0010011;

    typedef struct packed {
        logic [6:0]       op;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [TAG_W-1:0] src1_tag;
        logic [XLEN-1:0]  src1_data;
        logic             src1_valid;
        logic [TAG_W-1:0] src2_tag;
        logic [XLEN-1:0]  src2_data;
        logic             src2_valid;
        logic [TAG_W-1:0] rd_tag;
        logic [XLEN-1:0]  pc;
    } res_word;

    typedef struct packed {
        logic [XLEN-1:0] data;
    } cdb_data;
endpackage

interface res_dispatch_if #(parameter int unsigned NUM_RS = 5);
    logic                    iq_valid;
    tomasula_types::res_word iq_word;
    logic                    iq_pop;
    logic [NUM_RS-1:0]       res_empty;
    logic [NUM_RS-1:0]       load_word;
    tomasula_types::res_word res_out;
    tomasula_types::cdb_data cdb [8];
    logic [7:0]              robs_calculated;
    logic [7:0]              allocated_rob_entries;
    logic                    jalr_executed;
    logic                    flush;
    logic                    dispatch_stall;

    modport master (
        input  iq_valid, iq_word, res_empty, cdb, robs_calculated,
               allocated_rob_entries, jalr_executed, flush,
        output iq_pop, load_word, res_out, dispatch_stall
    );

    modport slave (
        output iq_valid, iq_word, res_empty, cdb, robs_calculated,
               allocated_rob_entries, jalr_executed, flush,
        input  iq_pop, load_word, res_out, dispatch_stall
    );
endinterface

// File: rtl/res_dispatch.sv
// Reservation-station dispatcher: holds one decoded word, merges CDB results into it and
// hands it to the next free station round-robin. DISPATCH_BYPASS_EN enables same-cycle IDLE dispatch.
module res_dispatch #(
    parameter int unsigned NUM_RS = 5
) (
    input  logic           clk,
    input  logic           rst,
    res_dispatch_if.master io_bus
);
    localparam int unsigned PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_HOLD      = 2'd1,
        S_WAIT_JALR = 2'd2
    } state_t;

    state_t                  r_state;
    logic [PTR_W-1:0]        r_rr_ptr;
    tomasula_types::res_word r_hold;
    logic                    r_post_rst;

    logic [7:0][31:0]        w_cdb_data;
    tomasula_types::res_word w_hold_m;
    tomasula_types::res_word w_iq_m;
    tomasula_types::res_word w_out;
    logic                    w_quiet;
    logic                    w_found;
    logic [PTR_W-1:0]        w_sel;
    logic [PTR_W-1:0]        w_idx;
    logic [PTR_W-1:0]        w_ptr_nxt;
    logic                    w_pop;
    logic [NUM_RS-1:0]       w_load;
    logic                    w_stall;
    logic                    w_capture;
    logic                    w_clear;
    logic                    w_adv;
    state_t                  w_next;

    // Fill any still-pending source whose producer is broadcasting this cycle.
    function automatic tomasula_types::res_word f_merge(
        input tomasula_types::res_word w,
        input logic [7:0]              calc,
        input logic [7:0][31:0]        data
    );
        tomasula_types::res_word m;
        m = w;
        if (!m.src1_valid && calc[m.src1_tag]) begin
            m.src1_valid = 1'b1;
            m.src1_data  = data[m.src1_tag];
        end
        if (!m.src2_valid && calc[m.src2_tag]) begin
            m.src2_valid = 1'b1;
            m.src2_data  = data[m.src2_tag];
        end
        return m;
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_cdb_data[i] = io_bus.cdb[i].data;
        end
    end

    assign w_hold_m = f_merge(r_hold, io_bus.robs_calculated, w_cdb_data);
    assign w_iq_m   = f_merge(io_bus.iq_word, io_bus.robs_calculated, w_cdb_data);
    // Reset cycle and the cycle right after it are kept silent on every output.
    assign w_quiet  = rst | r_post_rst;

    // First empty station at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            w_idx = PTR_W'((32'(r_rr_ptr) + i) % NUM_RS);
            if (!w_found && io_bus.res_empty[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
        w_ptr_nxt = (w_sel == PTR_W'(NUM_RS - 1)) ? '0 : w_sel + PTR_W'(1);
    end

    always_comb begin
        w_pop     = 1'b0;
        w_load    = '0;
        w_stall   = 1'b0;
        w_capture = 1'b0;
        w_clear   = 1'b0;
        w_adv     = 1'b0;
        w_next    = r_state;
        w_out     = w_hold_m;
        if (!w_quiet) begin
            if (io_bus.flush) begin
                w_next  = S_IDLE;
                w_clear = 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (io_bus.iq_valid) begin
                            w_pop = 1'b1;
`ifdef DISPATCH_BYPASS_EN
                            w_out = w_iq_m;
                            if (w_found && io_bus.allocated_rob_entries[io_bus.iq_word.rd_tag]) begin
                                w_load[w_sel] = 1'b1;
                                w_adv         = 1'b1;
                                w_next        = (io_bus.iq_word.op == tomasula_types::OP_JALR)
                                                ? S_WAIT_JALR : S_IDLE;
                            end else begin
                                w_capture = 1'b1;
                                w_next    = S_HOLD;
                            end
`else
                            w_capture = 1'b1;
                            w_next    = S_HOLD;
`endif
                        end
                    end
                    S_HOLD: begin
                        if (!io_bus.allocated_rob_entries[r_hold.rd_tag]) begin
                            w_next  = S_IDLE;
                            w_clear = 1'b1;
                        end else if (w_found) begin
                            w_load[w_sel] = 1'b1;
                            w_adv         = 1'b1;
                            if (r_hold.op == tomasula_types::OP_JALR) begin
                                w_next = S_WAIT_JALR;
                            end else if (io_bus.iq_valid) begin
                                w_pop     = 1'b1;
                                w_capture = 1'b1;
                            end else begin
                                w_next = S_IDLE;
                            end
                        end else begin
                            w_stall = 1'b1;
                        end
                    end
                    S_WAIT_JALR: begin
                        if (io_bus.jalr_executed) begin
                            w_next = S_IDLE;
                        end
                    end
                    default: w_next = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_hold     <= '0;
            r_post_rst <= 1'b1;
        end else begin
            r_post_rst <= 1'b0;
            r_state    <= w_next;
            if (w_adv) begin
                r_rr_ptr <= w_ptr_nxt;
            end
            if (w_clear) begin
                r_hold <= '0;
            end else if (w_capture) begin
                r_hold <= w_iq_m;
            end else if (r_state == S_HOLD) begin
                r_hold <= w_hold_m;
            end
        end
    end

    assign io_bus.iq_pop         = w_pop;
    assign io_bus.load_word      = w_load;
    assign io_bus.dispatch_stall = w_stall;
    assign io_bus.res_out        = w_quiet ? '0 : w_out;

endmodule
